kitchen_timer_mc: RTL

KITCHEN_TIMER_MC -- requirements
Module: kitchen_timer_mc

---
 rtl/kitchen_timer_mc.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/kitchen_timer_mc.sv
// kitchen_timer_mc: multi-channel BCD kitchen timer sharing one free-running one-second prescaler
module kitchen_timer_mc #(
    parameter int NUM_CH   = 2,
    parameter int TICK_DIV = 50000000,
    parameter int MAX_MIN  = 99,
    localparam int CW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [CW-1:0] ch_sel,
    input  logic [6:0]    num,
    input  logic          load_min,
    input  logic          load_sec,
    input  logic          start,
    input  logic          pause,
    input  logic          clear,
    input  logic          up,
    output logic [3:0]    disp_min_1,
    output logic [3:0]    disp_min_0,
    output logic [3:0]    disp_sec_1,
    output logic [3:0]    disp_sec_0,
    output logic [1:0]    disp_state,
    output logic [NUM_CH-1:0] done,
    output logic          led
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [15:0] MAX_V = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10), 4'd5, 4'd9};

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSED = 2'd2, DONE = 2'd3} state_t;

    state_t st [NUM_CH];
    state_t st_nxt [NUM_CH];
    logic [15:0] val [NUM_CH];
    logic [15:0] val_nxt [NUM_CH];
    logic [NUM_CH-1:0] dir, dir_nxt, sel;
    logic [4:0] prev;
    logic [PW-1:0] pre;
    logic tick, lm_e, ls_e, st_e, pa_e, cl_e;
    logic [15:0] disp_v;
    logic [1:0] ds;

    assign {lm_e, ls_e, st_e, pa_e, cl_e} = {load_min, load_sec, start, pause, clear} & ~prev;
    assign tick = (pre == PW'(TICK_DIV - 1));

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign sel[g]  = (ch_sel == CW'(g));
        assign done[g] = (st[g] == DONE);
    end

    assign led = |done;
    assign {disp_min_1, disp_min_0, disp_sec_1, disp_sec_0} = disp_v;
    assign disp_state = ds;

    function automatic logic [7:0] to_bcd(input logic [6:0] n, input int lim);
        logic [6:0] v;
        v = (int'(n) > lim) ? 7'(lim) : n;
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [3:0] a, b, c, d;
        {a, b, c, d} = v;
        if (d != 4'd0) d = d - 4'd1;
        else begin
            d = 4'd9;
            if (c != 4'd0) c = c - 4'd1;
            else begin
                c = 4'd5;
                if (b != 4'd0) b = b - 4'd1;
                else begin
                    b = 4'd9;
                    a = a - 4'd1;
                end
            end
        end
        return {a, b, c, d};
    endfunction

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [3:0] a, b, c, d;
        {a, b, c, d} = v;
        if (d != 4'd9) d = d + 4'd1;
        else begin
            d = 4'd0;
            if (c != 4'd5) c = c + 4'd1;
            else begin
                c = 4'd0;
                if (b != 4'd9) b = b + 4'd1;
                else begin
                    b = 4'd0;
                    a = a + 4'd1;
                end
            end
        end
        return {a, b, c, d};
    endfunction

    // per-channel next state: commands in priority order, otherwise count on tick
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            st_nxt[i]  = st[i];
            val_nxt[i] = val[i];
            dir_nxt[i] = dir[i];
            if (sel[i] && cl_e) begin
                st_nxt[i]  = IDLE;
                val_nxt[i] = '0;
            end else if (sel[i] && (lm_e || ls_e) && (st[i] == IDLE || st[i] == DONE)) begin
                st_nxt[i] = IDLE;
                if (lm_e) val_nxt[i][15:8] = to_bcd(num, MAX_MIN);
                if (ls_e) val_nxt[i][7:0] = to_bcd(num, 59);
            end else if (sel[i] && st_e && st[i] == IDLE) begin
                dir_nxt[i] = up;
                st_nxt[i]  = (!up && val[i] == 16'h0) ? DONE : RUN;
            end else if (sel[i] && (st_e || pa_e) && st[i] == PAUSED) begin
                st_nxt[i] = RUN;
            end else if (sel[i] && pa_e && st[i] == RUN) begin
                st_nxt[i] = PAUSED;
            end else if (tick && st[i] == RUN) begin
                // a channel already sitting at its terminal value stops instead of wrapping
                if (dir[i] ? val[i] == MAX_V : val[i] == 16'h0) st_nxt[i] = DONE;
                else begin
                    val_nxt[i] = dir[i] ? bcd_inc(val[i]) : bcd_dec(val[i]);
                    st_nxt[i]  = (val_nxt[i] == (dir[i] ? MAX_V : 16'h0)) ? DONE : RUN;
                end
            end
        end
    end

    // state registers, command edge samples and the shared prescaler
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pre  <= '0;
            prev <= '0;
            dir  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                st[i]  <= IDLE;
                val[i] <= '0;
            end
        end else begin
            pre  <= tick ? '0 : pre + 1'b1;
            prev <= {load_min, load_sec, start, pause, clear};
            dir  <= dir_nxt;
            for (int i = 0; i < NUM_CH; i++) begin
                st[i]  <= st_nxt[i];
                val[i] <= val_nxt[i];
            end
        end
    end

    // display mux of the selected channel; unselected range reads as zero
    always_comb begin
        disp_v = '0;
        ds     = 2'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel[i]) begin
                disp_v = val[i];
                ds     = st[i];
            end
        end
    end
endmodule
